costas_symbol_decider: RTL and testbench
========================================

Name: costas_symbol_decider

Overview:
- Sits directly downstream of the Costas loop. Consumes the baseband I/Q samples that follow the loop filter and truncation.
- Integrates and dumps I and Q over one symbol period to form soft symbols.
- Slices each soft symbol to hard BPSK or QPSK bits.
- Runs a windowed carrier-lock detector. Its output qualifies the bit stream for the downstream deframer.

Parameters:
- DATA_WIDTH, 16: width of the signed I/Q input samples.
- ACC_WIDTH, 24: signed width of the integrators and soft-symbol outputs; must be at least DATA_WIDTH + log2(SPS).
- SPS, 16: accepted samples per symbol; range 2..256.
- LOCK_WINDOW, 256: number of symbols per lock-evaluation window.
- LOCK_THRESH, 224: minimum count of good symbols in a window to declare lock.

Ports:
- clk_32M768, input, 1: system clock.
- rst_32M768, input, 1: reset, synchronous, active-high.
- I_data, input, DATA_WIDTH: signed in-phase sample.
- Q_data, input, DATA_WIDTH: signed quadrature sample.
- I_valid, input, 1: I sample valid.
- Q_valid, input, 1: Q sample valid.
- is_bpsk, input, 1: 1 = BPSK slicing, 0 = QPSK slicing.
- symbol_start, input, 1: symbol-boundary realignment strobe.
- sym_I, output, ACC_WIDTH: signed integrated I of the last symbol.
- sym_Q, output, ACC_WIDTH: signed integrated Q of the last symbol.
- sym_valid, output, 1: one-cycle pulse; new symbol on sym_I/sym_Q/sym_bits.
- sym_bits, output, 2: hard decision; bit1 = I bit, bit0 = Q bit (QPSK); BPSK uses bit0 only, bit1 = 0.
- sym_is_bpsk, output, 1: value of is_bpsk latched with this symbol.
- locked, output, 1: carrier-lock flag.
- good_count, output, 16: good-symbol count of the last completed window (zero-extended).

Behaviour:
- Reset: all outputs, both accumulators, the sample counter, the window counter and the running good counter go to 0. Reset asserted mid-symbol discards the partial symbol.
- Accepted sample: both I_valid and Q_valid are 1 in the same cycle. If only one is high, the cycle is ignored entirely.
- Accumulation:
  - Inputs are sign-extended to ACC_WIDTH.
  - Integrators wrap (two's complement) and do not saturate; the parameter constraint guarantees no overflow.
  - The sample counter runs 0..SPS-1 and increments on each accepted sample.
- Dump: on the accepted sample with counter = SPS-1:
  - sym_I = acc_I + I and sym_Q = acc_Q + Q, registered.
  - sym_valid pulses high the next cycle (latency 1 from the last sample).
  - Accumulators and counter clear to 0.
  - sym_is_bpsk latches is_bpsk in the same cycle.
- symbol_start:
  - With an accepted sample: that sample becomes sample 0 of a new symbol (acc = sample, counter = 1). The partial symbol is discarded and no sym_valid is produced, even if the counter was at SPS-1; symbol_start wins over dump.
  - Without an accepted sample: acc = 0 and counter = 0.
- Slicing (sign only):
  - BPSK: sym_bits = {1'b0, sym_I<0}.
  - QPSK: sym_bits = {sym_I<0, sym_Q<0}.
  - Zero maps to bit 0.
- Lock metric: evaluated in the cycle after sym_valid (pipeline stage 2).
  - Absolute values |x| are computed in ACC_WIDTH+1 bits, so the most-negative value is exact.
  - BPSK good: |I| >= 2·|Q|.
  - QPSK good: 2·min(|I|,|Q|) >= max(|I|,|Q|).
  - On each evaluation the window counter increments and the good counter increments if the symbol is good.
- Window end: on the evaluation of the LOCK_WINDOW-th symbol (including that symbol's result):
  - good_count takes the final count.
  - locked = (final count >= LOCK_THRESH).
  - Both counters clear.
  - locked and good_count change only at window end, therefore 2 cycles after the last sym_valid of the window.
- Mode change: if is_bpsk differs from the previous symbol's sym_is_bpsk at a dump, the window and good counters restart from 0 (this symbol counts as the first of the new window). locked and good_count hold their values.
- No backpressure: every dump produces a sym_valid; the downstream block must accept one symbol per SPS accepted samples.

Test Plan:
- Reset, then I = 1000, Q = 0, both valid every cycle, SPS = 16, BPSK:
  - sym_valid every 16 cycles, 1 cycle after the 16th sample.
  - sym_I = 16000, sym_Q = 0, sym_bits = 00.
  - After 256 symbols: locked = 1 and good_count = 256, 2 cycles after the last sym_valid.
- QPSK, I = -800, Q = 700 constant:
  - sym_I = -12800, sym_Q = 11200, sym_bits = 10, every symbol good.
  - BPSK with the same data: |I| < 2|Q|, so after a window locked = 0 and good_count = 0.
- symbol_start asserted together with the 16th sample: no sym_valid. The next sym_valid appears 15 accepted samples later with sym_I = 16·I.
- Valid gaps: I_valid = 1 with Q_valid = 0 for 5 cycles mid-symbol. Those cycles are ignored and the sums are unchanged. Toggling the valids every other cycle halves the symbol rate.
- Extremes: I = -32768, Q = 32767 for a whole symbol:
  - sym_I = -524288, sym_Q = 524272, no wrap in 24 bits.
  - QPSK good (|I| = 524288 exact).
- Mode switch at symbol 100 of a window: counters restart. locked holds its previous value until 256 symbols after the switch. A reset pulse mid-symbol clears all outputs next cycle.

Source files
------------

// File: rtl/costas_symbol_decider.sv
// costas_symbol_decider
//   Integrate-and-dump symbol former, hard-decision slicer and windowed
//   carrier-lock detector that sits behind the Costas loop.
//
//   Ports
//     clk_32M768, rst_32M768 : clock, synchronous active-high reset
//     I_data/Q_data          : signed baseband samples (DATA_WIDTH)
//     I_valid/Q_valid        : a sample is taken only when both are high
//     is_bpsk                : 1 = BPSK slicing/lock metric, 0 = QPSK
//     symbol_start           : realign; the current sample (if any) becomes sample 0
//     sym_I/sym_Q            : integrated soft symbol (ACC_WIDTH, signed)
//     sym_valid              : one-cycle strobe for sym_I/sym_Q/sym_bits
//     sym_bits               : {I bit, Q bit}; BPSK drives only bit0
//     sym_is_bpsk            : mode captured with the symbol
//     locked, good_count     : lock flag and good count of the last full window
//
//   Pipeline: dump edge -> sym_* / sym_valid (vld_pipe[0])
//             -> |I|,|Q| registered (vld_pipe[1]) -> window counters, lock.

// One integrate-and-dump lane (instantiated for I and for Q).
module costas_sym_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         accept,
  input  logic                         restart,
  input  logic                         dump,
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic signed [ACC_WIDTH-1:0]  sym
);
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sample_x;

  assign sample_x = {{(ACC_WIDTH-DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      sym <= '0;
    end else if (restart) begin
      // realignment drops the partial symbol; the accepted sample starts the next
      acc <= accept ? sample_x : '0;
    end else if (accept) begin
      if (dump) begin
        sym <= acc + sample_x;
        acc <= '0;
      end else begin
        acc <= acc + sample_x;
      end
    end
  end
endmodule

module costas_symbol_decider #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 24,
  parameter int SPS         = 16,
  parameter int LOCK_WINDOW = 256,
  parameter int LOCK_THRESH = 224
) (
  input  logic                         clk_32M768,
  input  logic                         rst_32M768,
  input  logic signed [DATA_WIDTH-1:0] I_data,
  input  logic signed [DATA_WIDTH-1:0] Q_data,
  input  logic                         I_valid,
  input  logic                         Q_valid,
  input  logic                         is_bpsk,
  input  logic                         symbol_start,
  output logic signed [ACC_WIDTH-1:0]  sym_I,
  output logic signed [ACC_WIDTH-1:0]  sym_Q,
  output logic                         sym_valid,
  output logic [1:0]                   sym_bits,
  output logic                         sym_is_bpsk,
  output logic                         locked,
  output logic [15:0]                  good_count
);
  localparam int NUM_LANES = 2;  // lane 0 = I, lane 1 = Q
  localparam int STAGES    = 1;
  localparam int CNT_W     = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int WIN_W     = $clog2(LOCK_WINDOW + 1);

  typedef struct packed {
    logic [ACC_WIDTH:0] abs_i;
    logic [ACC_WIDTH:0] abs_q;
    logic               bpsk;
    logic               chg;   // mode changed with this symbol: restart window
  } eval_t;

  logic [CNT_W-1:0]  cnt;
  logic              accept, last, dump;
  logic [STAGES:0]   vld_pipe;
  logic              sym_chg;
  eval_t             eval_q;
  logic [WIN_W-1:0]  win_cnt, good_run;
  logic [WIN_W-1:0]  win_nxt, good_nxt;
  logic              is_good;

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_sample;
  logic [NUM_LANES-1:0][ACC_WIDTH-1:0]  lane_sym;

  assign accept = I_valid & Q_valid;
  assign last   = (cnt == CNT_W'(SPS - 1));
  // symbol_start beats the dump of a symbol ending on the same sample
  assign dump   = accept & last & ~symbol_start;

  assign lane_sample = {Q_data, I_data};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    costas_sym_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk    (clk_32M768),
      .rst    (rst_32M768),
      .accept (accept),
      .restart(symbol_start),
      .dump   (dump),
      .sample (lane_sample[g]),
      .sym    (lane_sym[g])
    );
  end

  assign sym_I     = lane_sym[0];
  assign sym_Q     = lane_sym[1];
  assign sym_valid = vld_pipe[0];
  assign sym_bits  = sym_is_bpsk ? {1'b0, sym_I[ACC_WIDTH-1]}
                                 : {sym_I[ACC_WIDTH-1], sym_Q[ACC_WIDTH-1]};

  // sample counter
  always_ff @(posedge clk_32M768) begin
    if (rst_32M768)        cnt <= '0;
    else if (symbol_start) cnt <= accept ? CNT_W'(1) : '0;
    else if (accept)       cnt <= last ? '0 : cnt + CNT_W'(1);
  end

  // One extra bit so the most negative sum has an exact magnitude.
  function automatic logic [ACC_WIDTH:0] mag(input logic signed [ACC_WIDTH-1:0] x);
    logic signed [ACC_WIDTH:0] xe;
    xe = {x[ACC_WIDTH-1], x};
    return (xe < 0) ? -xe : xe;
  endfunction

  always_ff @(posedge clk_32M768) begin
    if (rst_32M768) begin
      vld_pipe    <= '0;
      sym_is_bpsk <= 1'b0;
      sym_chg     <= 1'b0;
      eval_q      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], dump};
      if (dump) begin
        sym_is_bpsk <= is_bpsk;
        sym_chg     <= (is_bpsk != sym_is_bpsk);
      end
      if (vld_pipe[0]) begin
        eval_q.abs_i <= mag(sym_I);
        eval_q.abs_q <= mag(sym_Q);
        eval_q.bpsk  <= sym_is_bpsk;
        eval_q.chg   <= sym_chg;
      end
    end
  end

  // lock metric on the registered magnitudes
  always_comb begin
    logic [ACC_WIDTH:0] mn, mx;
    is_good  = 1'b0;
    win_nxt  = '0;
    good_nxt = '0;
    mn = (eval_q.abs_i < eval_q.abs_q) ? eval_q.abs_i : eval_q.abs_q;
    mx = (eval_q.abs_i < eval_q.abs_q) ? eval_q.abs_q : eval_q.abs_i;
    if (eval_q.bpsk) is_good = ({1'b0, eval_q.abs_i} >= {eval_q.abs_q, 1'b0});
    else             is_good = ({mn, 1'b0} >= {1'b0, mx});
    win_nxt  = (eval_q.chg ? '0 : win_cnt) + WIN_W'(1);
    good_nxt = (eval_q.chg ? '0 : good_run) + WIN_W'(is_good);
  end

  always_ff @(posedge clk_32M768) begin
    if (rst_32M768) begin
      win_cnt    <= '0;
      good_run   <= '0;
      locked     <= 1'b0;
      good_count <= '0;
    end else if (vld_pipe[STAGES]) begin
      if (win_nxt == WIN_W'(LOCK_WINDOW)) begin
        good_count <= 16'(good_nxt);
        locked     <= (good_nxt >= WIN_W'(LOCK_THRESH));
        win_cnt    <= '0;
        good_run   <= '0;
      end else begin
        win_cnt  <= win_nxt;
        good_run <= good_nxt;
      end
    end
  end
endmodule

// File: tb/tb_costas_symbol_decider.sv
module tb_costas_symbol_decider;
  localparam int DATA_WIDTH  = 16;
  localparam int ACC_WIDTH   = 24;
  localparam int SPS         = 16;
  localparam int LOCK_WINDOW = 256;
  localparam int LOCK_THRESH = 224;

  logic clk_32M768 = 1'b0;
  logic rst_32M768 = 1'b1;
  logic signed [DATA_WIDTH-1:0] I_data = '0, Q_data = '0;
  logic I_valid = 1'b0, Q_valid = 1'b0, is_bpsk = 1'b0, symbol_start = 1'b0;
  logic signed [ACC_WIDTH-1:0] sym_I, sym_Q;
  logic sym_valid, sym_is_bpsk, locked;
  logic [1:0] sym_bits;
  logic [15:0] good_count;

  costas_symbol_decider #(
    .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .SPS(SPS),
    .LOCK_WINDOW(LOCK_WINDOW), .LOCK_THRESH(LOCK_THRESH)
  ) dut (
    .clk_32M768(clk_32M768), .rst_32M768(rst_32M768),
    .I_data(I_data), .Q_data(Q_data), .I_valid(I_valid), .Q_valid(Q_valid),
    .is_bpsk(is_bpsk), .symbol_start(symbol_start),
    .sym_I(sym_I), .sym_Q(sym_Q), .sym_valid(sym_valid), .sym_bits(sym_bits),
    .sym_is_bpsk(sym_is_bpsk), .locked(locked), .good_count(good_count)
  );

  always #5 clk_32M768 = ~clk_32M768;

  int n_vec = 0, n_err = 0;

  // behavioural reference: symbol sums as integers, lock as window tallies
  longint m_acc_i, m_acc_q;
  int     m_n, m_win, m_good, m_pend, m_pend_good, m_exp_good, m_sym_cnt;
  bit     m_last_mode, m_pend_lock, m_exp_lock;

  function automatic longint labs(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    m_acc_i = 0; m_acc_q = 0; m_n = 0; m_win = 0; m_good = 0;
    m_pend = 0; m_last_mode = 0; m_exp_lock = 0; m_exp_good = 0;
  endtask

  // One clock: drive at negedge, step the model, check at the next negedge.
  task automatic drive_cycle(input bit iv, input bit qv, input int di, input int dq,
                             input bit ss, input bit bpsk);
    bit emit, good;
    longint si, sq, ai, aq, mn, mx;
    logic [1:0] eb;
    I_valid = iv; Q_valid = qv; I_data = 16'(di); Q_data = 16'(dq);
    symbol_start = ss; is_bpsk = bpsk;
    if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin m_exp_lock = m_pend_lock; m_exp_good = m_pend_good; end
    end
    emit = 0; si = 0; sq = 0;
    if (ss) begin
      if (iv && qv) begin m_acc_i = di; m_acc_q = dq; m_n = 1; end
      else begin m_acc_i = 0; m_acc_q = 0; m_n = 0; end
    end else if (iv && qv) begin
      m_acc_i += di; m_acc_q += dq; m_n++;
      if (m_n == SPS) begin
        emit = 1; si = m_acc_i; sq = m_acc_q;
        m_acc_i = 0; m_acc_q = 0; m_n = 0; m_sym_cnt++;
        if (bpsk != m_last_mode) begin m_win = 0; m_good = 0; end
        m_last_mode = bpsk;
        ai = labs(si); aq = labs(sq);
        mn = (ai < aq) ? ai : aq; mx = (ai < aq) ? aq : ai;
        good = bpsk ? (ai >= 2 * aq) : (2 * mn >= mx);
        m_win++; m_good += int'(good);
        if (m_win == LOCK_WINDOW) begin
          m_pend = 2; m_pend_lock = (m_good >= LOCK_THRESH); m_pend_good = m_good;
          m_win = 0; m_good = 0;
        end
      end
    end
    @(posedge clk_32M768); @(negedge clk_32M768);
    n_vec++;
    if (sym_valid !== emit) begin
      n_err++; $display("FAIL sym_valid t=%0t got %b exp %b", $time, sym_valid, emit);
    end
    if (emit) begin
      eb = bpsk ? {1'b0, si < 0} : {si < 0, sq < 0};
      n_vec++;
      if (sym_I !== ACC_WIDTH'(si) || sym_Q !== ACC_WIDTH'(sq)) begin
        n_err++; $display("FAIL sym_iq t=%0t got %0d/%0d exp %0d/%0d", $time, sym_I, sym_Q, si, sq);
      end
      n_vec++;
      if (sym_bits !== eb || sym_is_bpsk !== bpsk) begin
        n_err++; $display("FAIL sym_bits t=%0t got %b/%b exp %b/%b", $time, sym_bits, sym_is_bpsk, eb, bpsk);
      end
    end
    n_vec++;
    if (locked !== m_exp_lock || good_count !== 16'(m_exp_good)) begin
      n_err++; $display("FAIL lock t=%0t got %b/%0d exp %b/%0d", $time, locked, good_count, m_exp_lock, m_exp_good);
    end
  endtask

  task automatic do_reset();
    rst_32M768 = 1'b1; I_valid = 0; Q_valid = 0; symbol_start = 0;
    @(posedge clk_32M768); @(negedge clk_32M768);
    rst_32M768 = 1'b0;
    model_reset();
    n_vec++;
    if (sym_valid !== 0 || sym_I !== 0 || sym_Q !== 0 || sym_bits !== 0 ||
        sym_is_bpsk !== 0 || locked !== 0 || good_count !== 0) begin
      n_err++;
      $display("FAIL reset got v=%b I=%0d Q=%0d b=%b m=%b l=%b g=%0d exp all 0",
               sym_valid, sym_I, sym_Q, sym_bits, sym_is_bpsk, locked, good_count);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic run_syms(input int nsym, input int di, input int dq, input bit bpsk);
    for (int k = 0; k < nsym * SPS; k++) drive_cycle(1, 1, di, dq, 0, bpsk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(0, 0, 0, 0, 0, is_bpsk);
  endtask

  task automatic test_bpsk_lock();
    run_syms(1, 1000, 0, 1);
    n_vec++;
    if (sym_I !== 24'sd16000 || sym_Q !== 0 || sym_bits !== 2'b00) begin
      n_err++; $display("FAIL bpsk_sym got %0d/%0d/%b exp 16000/0/00", sym_I, sym_Q, sym_bits);
    end
    run_syms(LOCK_WINDOW - 1, 1000, 0, 1);
    idle(1);
    n_vec++;
    if (locked !== 0) begin n_err++; $display("FAIL bpsk_lock_early got %b exp 0", locked); end
    idle(1);
    n_vec++;
    if (locked !== 1 || good_count !== 16'd256) begin
      n_err++; $display("FAIL bpsk_lock got %b/%0d exp 1/256", locked, good_count);
    end
  endtask

  task automatic test_qpsk();
    run_syms(1, -800, 700, 0);
    n_vec++;
    if (sym_I !== -24'sd12800 || sym_Q !== 24'sd11200 || sym_bits !== 2'b10) begin
      n_err++; $display("FAIL qpsk_sym got %0d/%0d/%b exp -12800/11200/10", sym_I, sym_Q, sym_bits);
    end
    run_syms(LOCK_WINDOW - 1, -800, 700, 0);
    idle(2);
    n_vec++;
    if (locked !== 1 || good_count !== 16'd256) begin
      n_err++; $display("FAIL qpsk_lock got %b/%0d exp 1/256", locked, good_count);
    end
    run_syms(LOCK_WINDOW, -800, 700, 1);
    idle(2);
    n_vec++;
    if (locked !== 0 || good_count !== 16'd0) begin
      n_err++; $display("FAIL bpsk_unlock got %b/%0d exp 0/0", locked, good_count);
    end
  endtask

  task automatic test_symbol_start();
    int nv;
    do_reset();
    for (int k = 0; k < SPS - 1; k++) drive_cycle(1, 1, 300, -200, 0, 0);
    drive_cycle(1, 1, 300, -200, 1, 0);
    n_vec++;
    if (sym_valid !== 0) begin n_err++; $display("FAIL ss_nodump got %b exp 0", sym_valid); end
    nv = 0;
    for (int k = 0; k < SPS - 1; k++) begin
      drive_cycle(1, 1, 300, -200, 0, 0);
      nv += int'(sym_valid);
    end
    n_vec++;
    if (nv != 1 || sym_I !== 24'sd4800) begin
      n_err++; $display("FAIL ss_realign got %0d syms I=%0d exp 1 syms I=4800", nv, sym_I);
    end
    // symbol_start without a sample: empty restart
    for (int k = 0; k < 5; k++) drive_cycle(1, 1, 77, 11, 0, 0);
    drive_cycle(0, 1, 0, 0, 1, 0);
    run_syms(1, 9, -9, 0);
  endtask

  task automatic test_gaps();
    int nv;
    do_reset();
    for (int k = 0; k < 6; k++) drive_cycle(1, 1, 100, 50, 0, 0);
    for (int k = 0; k < 5; k++) drive_cycle(1, 0, 30000, -30000, 0, 0);
    for (int k = 0; k < SPS - 6; k++) drive_cycle(1, 1, 100, 50, 0, 0);
    n_vec++;
    if (sym_I !== 24'sd1600 || sym_Q !== 24'sd800) begin
      n_err++; $display("FAIL gap_sum got %0d/%0d exp 1600/800", sym_I, sym_Q);
    end
    nv = 0;
    for (int k = 0; k < 4 * SPS; k++) begin
      drive_cycle(k[0], k[0], $urandom_range(0, 4000) - 2000, $urandom_range(0, 4000) - 2000, 0, 0);
      nv += int'(sym_valid);
    end
    n_vec++;
    if (nv != 2) begin n_err++; $display("FAIL half_rate got %0d syms exp 2", nv); end
  endtask

  task automatic test_extremes();
    do_reset();
    run_syms(1, -32768, 32767, 0);
    n_vec++;
    if (sym_I !== -24'sd524288 || sym_Q !== 24'sd524272 || sym_bits !== 2'b10) begin
      n_err++; $display("FAIL extreme got %0d/%0d/%b exp -524288/524272/10", sym_I, sym_Q, sym_bits);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    run_syms(LOCK_WINDOW + 100, 500, -450, 0);
    run_syms(LOCK_WINDOW - 1, -800, 700, 1);
    idle(2);
    n_vec++;
    if (locked !== 1 || good_count !== 16'd256) begin
      n_err++; $display("FAIL mode_hold got %b/%0d exp 1/256", locked, good_count);
    end
    run_syms(1, -800, 700, 1);
    idle(2);
    n_vec++;
    if (locked !== 0 || good_count !== 16'd0) begin
      n_err++; $display("FAIL mode_window got %b/%0d exp 0/0", locked, good_count);
    end
  endtask

  task automatic test_random();
    bit mode = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) mode = ~mode;
      drive_cycle($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                  $urandom_range(0, 199) == 0, mode);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 7; k++) drive_cycle(1, 1, 1234, -4321, 0, 1);
    do_reset();
    run_syms(1, 25, 5, 1);
  endtask

  initial begin
    m_sym_cnt = 0;
    model_reset();
    @(negedge clk_32M768);
    @(negedge clk_32M768);
    test_reset();
    test_bpsk_lock();
    test_qpsk();
    test_symbol_start();
    test_gaps();
    test_extremes();
    test_random();
    test_reset_mid();
    test_mode_switch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
